// File: rtl/cdb_arb.sv
// -----------------------------------------------------------------------------
// cdb_arb : round-robin arbiter for the common data bus (CDB)
//
// Chooses one completed execution-unit result per cycle. The chosen result is
// registered and then broadcast to the reservation stations, the ROB and the
// register file.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   flush          ROB flush: blocks this cycle's grant and drops the next cdb_wr
//   req            per-EXU result valid (held until granted)
//   req_tag        flattened per-EXU tags        (EXU k: [k*TAG_W +: TAG_W])
//   req_inst_id    flattened per-EXU ROB indices (EXU k: [k*ROB_PTR_W +: ROB_PTR_W])
//   req_wdata      flattened per-EXU result data (EXU k: [k*DATA_W +: DATA_W])
//   gnt            one-hot combinational grant
//   cdb_wr         broadcast valid (registered, one cycle after the grant)
//   cdb_tag        broadcast tag
//   cdb_inst_id    broadcast ROB index
//   cdb_wdata      broadcast data
//   cdb_src        index of the EXU that owns the current broadcast
//   err_tag0       sticky flag: a granted request carried the reserved tag 0
// -----------------------------------------------------------------------------
module cdb_arb #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned ROB_PTR_W = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned IDX_W     = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*TAG_W-1:0]     req_tag,
   input  logic [N_REQ*ROB_PTR_W-1:0] req_inst_id,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   output logic [N_REQ-1:0]           gnt,
   output logic                       cdb_wr,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [ROB_PTR_W-1:0]       cdb_inst_id,
   output logic [DATA_W-1:0]          cdb_wdata,
   output logic [IDX_W-1:0]           cdb_src,
   output logic                       err_tag0
);

   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 cdb_wr_q;
   logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
   logic [ROB_PTR_W-1:0] cdb_inst_id_q, cdb_inst_id_d;
   logic [DATA_W-1:0]    cdb_wdata_q, cdb_wdata_d;
   logic [IDX_W-1:0]     cdb_src_q;
   logic                 err_tag0_q;

   logic                 found;
   logic [IDX_W-1:0]     win;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W:0]       sum;

   // Search starting at rr_ptr, wrapping explicitly so N_REQ need not be a
   // power of two. One extra bit in sum holds rr_ptr+i before the wrap.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      sum   = '0;
      if (!flush) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
               sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
               found = 1'b1;
               win   = cand;
            end
         end
      end
   end

   // Grant decode and payload mux for the winning lane.
   always_comb begin
      gnt           = '0;
      cdb_tag_d     = cdb_tag_q;
      cdb_inst_id_d = cdb_inst_id_q;
      cdb_wdata_d   = cdb_wdata_q;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (found && (win == IDX_W'(k))) begin
            gnt[k]        = 1'b1;
            cdb_tag_d     = req_tag[k*TAG_W +: TAG_W];
            cdb_inst_id_d = req_inst_id[k*ROB_PTR_W +: ROB_PTR_W];
            cdb_wdata_d   = req_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (found) begin
         rr_ptr_d = (win == IDX_W'(N_REQ-1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q      <= '0;
         cdb_wr_q      <= 1'b0;
         cdb_tag_q     <= '0;
         cdb_inst_id_q <= '0;
         cdb_wdata_q   <= '0;
         cdb_src_q     <= '0;
         err_tag0_q    <= 1'b0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         cdb_wr_q      <= found;
         cdb_tag_q     <= cdb_tag_d;
         cdb_inst_id_q <= cdb_inst_id_d;
         cdb_wdata_q   <= cdb_wdata_d;
         if (found) begin
            cdb_src_q <= win;
         end
         if (found && (cdb_tag_d == '0)) begin
            err_tag0_q <= 1'b1;
         end
      end
   end

   assign cdb_wr      = cdb_wr_q;
   assign cdb_tag     = cdb_tag_q;
   assign cdb_inst_id = cdb_inst_id_q;
   assign cdb_wdata   = cdb_wdata_q;
   assign cdb_src     = cdb_src_q;
   assign err_tag0    = err_tag0_q;

endmodule

// File: tb/tb_cdb_arb.sv
// -----------------------------------------------------------------------------
// tb_cdb_arb : directed self-checking bench for cdb_arb (N_REQ=4 defaults)
// -----------------------------------------------------------------------------
module tb_cdb_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned TW = 4;
   localparam int unsigned RW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 2;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic [N-1:0]    req;
   logic [N*TW-1:0] req_tag;
   logic [N*RW-1:0] req_inst_id;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt;
   logic            cdb_wr;
   logic [TW-1:0]   cdb_tag;
   logic [RW-1:0]   cdb_inst_id;
   logic [DW-1:0]   cdb_wdata;
   logic [IW-1:0]   cdb_src;
   logic            err_tag0;

   logic [TW-1:0]   tag_a  [N];
   logic [RW-1:0]   id_a   [N];
   logic [DW-1:0]   data_a [N];

   int checks;
   int errors;

   cdb_arb #(
      .N_REQ     (N),
      .TAG_W     (TW),
      .ROB_PTR_W (RW),
      .DATA_W    (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .req         (req),
      .req_tag     (req_tag),
      .req_inst_id (req_inst_id),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .cdb_wr      (cdb_wr),
      .cdb_tag     (cdb_tag),
      .cdb_inst_id (cdb_inst_id),
      .cdb_wdata   (cdb_wdata),
      .cdb_src     (cdb_src),
      .err_tag0    (err_tag0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         req_tag[k*TW +: TW]     = tag_a[k];
         req_inst_id[k*RW +: RW] = id_a[k];
         req_wdata[k*DW +: DW]   = data_a[k];
      end
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (cdb_wr !== 1'b0 || cdb_tag !== '0 || cdb_inst_id !== '0 ||
          cdb_wdata !== '0 || cdb_src !== '0 || err_tag0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: wr=%b tag=%h id=%h data=%h src=%0d err=%b, expected all zero",
                  cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata, cdb_src, err_tag0);
      end
      checks++;
      if (dut.rr_ptr_q !== 2'd0) begin
         errors++;
         $display("FAIL reset_ptr: rr_ptr=%0d expected 0", dut.rr_ptr_q);
      end
   endtask

   task automatic test_idle();
      req = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL idle_gnt[%0d]: gnt=%b expected 0000", c, gnt);
         end
         step();
         checks++;
         if (cdb_wr !== 1'b0) begin
            errors++;
            $display("FAIL idle_wr[%0d]: cdb_wr=%b expected 0", c, cdb_wr);
         end
      end
      checks++;
      if (err_tag0 !== 1'b0) begin
         errors++;
         $display("FAIL idle_err: err_tag0=%b expected 0", err_tag0);
      end
   endtask

   task automatic test_single();
      tag_a[2] = 4'd3; id_a[2] = 4'd7; data_a[2] = 32'hDEADBEEF;
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL single_gnt: gnt=%b expected 0100", gnt);
      end
      step();
      req = '0;
      checks++;
      if (cdb_wr !== 1'b1 || cdb_tag !== 4'd3 || cdb_inst_id !== 4'd7 ||
          cdb_wdata !== 32'hDEADBEEF || cdb_src !== 2'd2) begin
         errors++;
         $display("FAIL single_bcast: wr=%b tag=%0d id=%0d data=%h src=%0d expected 1/3/7/deadbeef/2",
                  cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata, cdb_src);
      end
      checks++;
      if (dut.rr_ptr_q !== 2'd3) begin
         errors++;
         $display("FAIL single_ptr: rr_ptr=%0d expected 3", dut.rr_ptr_q);
      end
      step();
      checks++;
      if (cdb_wr !== 1'b0 || cdb_tag !== 4'd3 || cdb_wdata !== 32'hDEADBEEF || cdb_src !== 2'd2) begin
         errors++;
         $display("FAIL single_hold: wr=%b tag=%0d data=%h src=%0d expected 0/3/deadbeef/2",
                  cdb_wr, cdb_tag, cdb_wdata, cdb_src);
      end
   endtask

   task automatic test_all_four();
      logic [IW-1:0] exp_seq [5];
      logic [N-1:0]  exp_g;
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      // Pointer is 3 here; one grant to EXU3 wraps it back to 0.
      req = 4'b1000;
      step();
      for (int k = 0; k < N; k++) begin
         tag_a[k] = TW'(k + 1); id_a[k] = RW'(k + 8); data_a[k] = 32'h1000 + DW'(k);
      end
      req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         exp_g = 4'b0001 << exp_seq[c];
         checks++;
         if (gnt !== exp_g) begin
            errors++;
            $display("FAIL all4_gnt[%0d]: gnt=%b expected %b", c, gnt, exp_g);
         end
         step();
         checks++;
         if (cdb_wr !== 1'b1 || cdb_src !== exp_seq[c] || cdb_tag !== TW'(exp_seq[c] + 1) ||
             cdb_wdata !== 32'h1000 + DW'(exp_seq[c])) begin
            errors++;
            $display("FAIL all4_bcast[%0d]: wr=%b src=%0d tag=%0d data=%h expected 1/%0d/%0d/%h",
                     c, cdb_wr, cdb_src, cdb_tag, cdb_wdata, exp_seq[c], exp_seq[c] + 1,
                     32'h1000 + DW'(exp_seq[c]));
         end
      end
      req = '0;
      step();
      checks++;
      if (cdb_wr !== 1'b0) begin
         errors++;
         $display("FAIL all4_drop: cdb_wr=%b expected 0", cdb_wr);
      end
   endtask

   task automatic test_fairness_wrap();
      // Pointer is 1; granting EXU2 moves it to 3.
      req = 4'b0100;
      step();
      req = 4'b1001;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_gnt_a: gnt=%b expected 1000", gnt);
      end
      step();
      #1;
      checks++;
      if (cdb_src !== 2'd3 || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_gnt_b: src=%0d gnt=%b expected 3/0001", cdb_src, gnt);
      end
      step();
      #1;
      checks++;
      if (cdb_src !== 2'd0 || dut.rr_ptr_q !== 2'd1 || gnt !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_gnt_c: src=%0d ptr=%0d gnt=%b expected 0/1/1000",
                  cdb_src, dut.rr_ptr_q, gnt);
      end
      step();
      req = '0;
      checks++;
      if (cdb_src !== 2'd3 || cdb_wr !== 1'b1 || dut.rr_ptr_q !== 2'd0) begin
         errors++;
         $display("FAIL wrap_bcast: src=%0d wr=%b ptr=%0d expected 3/1/0",
                  cdb_src, cdb_wr, dut.rr_ptr_q);
      end
   endtask

   task automatic test_flush();
      req = 4'b0011;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL flush_pre_gnt: gnt=%b expected 0001", gnt);
      end
      step();
      flush = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000 || cdb_wr !== 1'b1 || cdb_src !== 2'd0) begin
         errors++;
         $display("FAIL flush_cycle: gnt=%b wr=%b src=%0d expected 0000/1/0", gnt, cdb_wr, cdb_src);
      end
      step();
      flush = 1'b0;
      checks++;
      if (cdb_wr !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin
         errors++;
         $display("FAIL flush_after: wr=%b ptr=%0d expected 0/1", cdb_wr, dut.rr_ptr_q);
      end
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL flush_resume_gnt: gnt=%b expected 0010", gnt);
      end
      step();
      req = '0;
      checks++;
      if (cdb_wr !== 1'b1 || cdb_src !== 2'd1 || cdb_tag !== 4'd2) begin
         errors++;
         $display("FAIL flush_resume_bcast: wr=%b src=%0d tag=%0d expected 1/1/2",
                  cdb_wr, cdb_src, cdb_tag);
      end
   endtask

   task automatic test_tag0_reset();
      checks++;
      if (err_tag0 !== 1'b0) begin
         errors++;
         $display("FAIL tag0_pre: err_tag0=%b expected 0", err_tag0);
      end
      tag_a[0] = 4'd0; data_a[0] = 32'h5;
      req = 4'b0001;
      step();
      req = '0;
      checks++;
      if (cdb_wr !== 1'b1 || cdb_tag !== 4'd0 || cdb_wdata !== 32'h5 || err_tag0 !== 1'b1) begin
         errors++;
         $display("FAIL tag0_bcast: wr=%b tag=%0d data=%h err=%b expected 1/0/5/1",
                  cdb_wr, cdb_tag, cdb_wdata, err_tag0);
      end
      tag_a[3] = 4'd9; data_a[3] = 32'h77;
      req = 4'b1000;
      step();
      req = '0;
      step();
      checks++;
      if (err_tag0 !== 1'b1) begin
         errors++;
         $display("FAIL tag0_sticky: err_tag0=%b expected 1", err_tag0);
      end
      req = 4'b0010;
      step();
      req = '0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cdb_wr !== 1'b0 || err_tag0 !== 1'b0 || cdb_tag !== '0 || cdb_src !== '0 ||
          dut.rr_ptr_q !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: wr=%b err=%b tag=%0d src=%0d ptr=%0d expected all 0",
                  cdb_wr, err_tag0, cdb_tag, cdb_src, dut.rr_ptr_q);
      end
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      flush  = 1'b0;
      req    = '0;
      for (int k = 0; k < N; k++) begin
         tag_a[k] = TW'(k + 1); id_a[k] = '0; data_a[k] = '0;
      end
      #3;
      test_reset();
      #9;
      rst_n = 1'b1;
      test_idle();
      test_single();
      test_all_four();
      test_fairness_wrap();
      test_flush();
      test_tag0_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Round-robin arbiter that shares the single common data bus (CDB) among N_REQ execution units.
- Each EXU presents a completed result (tag, inst_id, wdata). The block grants one EXU per cycle and drives the registered CDB broadcast consumed by the reservation stations, the ROB and the register file.
- Sits between the EXU result outputs and cdb_itf in the core top.

Parameters:
N_REQ, 4, number of requesting execution units (>=2)
TAG_W, 4, reservation-station tag width
ROB_PTR_W, 4, ROB index width carried as inst_id
DATA_W, 32, result data width
IDX_W, $clog2(N_REQ), winner index width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  ROB flush; kills current arbitration and the pending broadcast
req  in  N_REQ  per-EXU result valid
req_tag  in  N_REQ*TAG_W  flattened tags; EXU k uses bits [k*TAG_W +: TAG_W]
req_inst_id  in  N_REQ*ROB_PTR_W  flattened ROB indices
req_wdata  in  N_REQ*DATA_W  flattened result data
gnt  out  N_REQ  one-hot grant, combinational
cdb_wr  out  1  broadcast valid
cdb_tag  out  TAG_W  broadcast tag
cdb_inst_id  out  ROB_PTR_W  broadcast ROB index
cdb_wdata  out  DATA_W  broadcast data
cdb_src  out  IDX_W  index of the EXU that owns the current broadcast
err_tag0  out  1  sticky: a granted request carried tag 0

Behaviour:
- Reset (rst_n low, async): rr_ptr=0; cdb_wr=0, cdb_tag=0, cdb_inst_id=0, cdb_wdata=0, cdb_src=0, err_tag0=0.
- Handshake is valid/ready:
  - EXU k holds req[k] and its payload stable until it samples gnt[k]=1 at a rising edge.
  - The transfer completes on that edge. EXU k may present a new result in the following cycle.
- Grant (combinational):
  - Search req starting at index rr_ptr, ascending, wrapping modulo N_REQ. The first set bit wins; gnt is one-hot on the winner.
  - gnt=0 when req=0 or flush=1.
- Pointer: on any edge with a grant, rr_ptr <= (winner+1) mod N_REQ. Wrap is explicit, and N_REQ need not be a power of 2. Otherwise rr_ptr holds, including during flush.
- Broadcast register, latency 1 cycle from grant to bus:
  - cdb_wr <= |gnt.
  - On a grant, cdb_tag/cdb_inst_id/cdb_wdata/cdb_src <= winner's payload and index.
  - With no grant, payload regs hold their last values and only cdb_wr drops.
- Throughput: one broadcast per cycle max. Back-to-back grants give back-to-back cdb_wr.
- Flush:
  - flush=1 at an edge forces cdb_wr <= 0 and grants nothing that cycle.
  - A broadcast already on the bus during the flush cycle remains visible for that cycle only.
  - Requesters are responsible for dropping their own req on flush. The arbiter does not store requests, so nothing is lost internally.
- Tag 0 is reserved as "no tag" by the reservation stations. A granted request with tag 0 is still forwarded, and err_tag0 <= 1 (sticky until reset).
- No starvation: any held req[k] is granted within N_REQ cycles of being asserted.
- Simultaneous events:
  - Flush and req in the same cycle: flush wins, and rr_ptr is unchanged.
  - Reset asserted mid-broadcast clears cdb_wr immediately (async).
- Reset deassertion is synchronized externally. The block only requires rst_n to be released away from the clk edge.

Test Plan:
- Reset then idle, req=0 for 5 cycles -> gnt=0 and cdb_wr=0 every cycle; err_tag0=0.
- Single request: req=4'b0100, tag=3, inst_id=7, wdata=0xDEADBEEF at cycle 0 -> gnt=4'b0100 in cycle 0; cycle 1 shows cdb_wr=1, cdb_tag=3, cdb_inst_id=7, cdb_wdata=0xDEADBEEF, cdb_src=2; rr_ptr=3.
- All four req held continuously from rr_ptr=0 -> grants in order 0,1,2,3,0. cdb_wr=1 on 5 consecutive cycles, and cdb_src follows the same sequence one cycle later.
- Fairness after wrap: rr_ptr=3, req=4'b1001 -> EXU3 granted first, then EXU0. A further req=4'b1001 afterwards -> EXU3 granted (ptr=1 searches 1,2,3).
- Flush: req=4'b0011 with flush=1 -> gnt=0; next cycle cdb_wr=0 and rr_ptr unchanged. The following cycle without flush grants the EXU at rr_ptr.
- Tag-0 error: granted request with tag=0, wdata=0x5 -> cdb_wr=1 with cdb_tag=0; err_tag0=1 from the next cycle onward and cleared only by asserting rst_n=0 asynchronously mid-cycle, which also drops cdb_wr at once.
